// File: rtl/lcd_fmt_pkg.sv
// rtl/lcd_fmt_pkg.sv - shared constants and helpers for the LCD message formatter
package lcd_fmt_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_CONVERT = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // ASCII characters used by the message
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  // Default set-DDRAM commands for the two display lines
  localparam logic [7:0] LINE1_ADDR_DEF = 8'h80;
  localparam logic [7:0] LINE2_ADDR_DEF = 8'hC0;

  // Two cursor commands plus two 16-character lines
  localparam int MSG_LEN = 34;

  // Four-character mnemonic, first character in the top byte
  function automatic logic [31:0] mnemonic(input logic [3:0] op);
    logic [31:0] m;
    case (op)
      4'd0:    m = "LOAD";
      4'd1:    m = "ADD ";
      4'd2:    m = "ADDI";
      4'd3:    m = "SUB ";
      4'd4:    m = "SUBI";
      4'd5:    m = "MUL ";
      4'd6:    m = "CLR ";
      4'd7:    m = "DPL ";
      default: m = {4{ASCII_QMARK}};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 16-cycle iterative double-dabble, 16-bit binary to 5 BCD digits
module bin2bcd_seq
  import lcd_fmt_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [19:0] bcd,
  output logic        ready
);

  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [19:0] bcd_adj;

  // Add 3 to every digit that is 5 or more so the following shift carries correctly
  function automatic logic [19:0] dabble_adjust(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 0; i < 5; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Load performs the first shift directly (all-zero digits need no adjust); 15 more follow
  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    bcd_adj = dabble_adjust(bcd_q);
    if (load) begin
      bcd_d = {19'd0, load_val[15]};
      bin_d = {load_val[14:0], 1'b0};
      cnt_d = 5'd15;
    end else if (cnt_q != 5'd0) begin
      bcd_d = {bcd_adj[18:0], bin_q[15]};
      bin_d = {bin_q[14:0], 1'b0};
      cnt_d = cnt_q - 5'd1;
    end
  end

  // Converter state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd   = bcd_q;
  assign ready = (cnt_q == 5'd0) && !load;

endmodule

// File: rtl/lcd_msg_formatter.sv
// rtl/lcd_msg_formatter.sv - formats an instruction result into a two-line LCD message stream
module lcd_msg_formatter
  import lcd_fmt_pkg::*;
#(
  parameter int          LINE_LEN   = 16,
  parameter logic [7:0]  LINE1_ADDR = LINE1_ADDR_DEF,
  parameter logic [7:0]  LINE2_ADDR = LINE2_ADDR_DEF,
  parameter logic [7:0]  PAD_CHAR   = ASCII_SPACE
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [3:0]  dest_reg_addr,
  input  logic [15:0] alu_result,
  input  logic        char_ready,
  output logic        char_valid,
  output logic [7:0]  char_data,
  output logic        char_is_cmd,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] L2_IDX   = 6'(LINE_LEN + 1);
  localparam logic [5:0] LAST_IDX = 6'(MSG_LEN - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [3:0]  dest_q, dest_d;
  logic [15:0] res_q, res_d;
  logic        sign_q, sign_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        cmd_q, cmd_d;

  logic        bcd_load;
  logic [15:0] mag;
  logic [19:0] bcd_digits;
  logic        bcd_ready;

  logic [5:0]  nxt_idx;
  logic [7:0]  nxt_byte;
  logic        nxt_cmd;
  logic [31:0] mnem;
  logic        dest_tens;
  logic [3:0]  dest_ones;
  logic [3:0]  l1_pos, l2_pos;

  // Magnitude of the captured result; 16'h8000 naturally maps to 32768
  assign mag = res_q[15] ? (~res_q + 16'd1) : res_q;

  bin2bcd_seq u_bcd (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (bcd_load),
    .load_val (mag),
    .bcd      (bcd_digits),
    .ready    (bcd_ready)
  );

  // Byte that follows the current index in the fixed message layout
  always_comb begin
    nxt_idx   = idx_q + 6'd1;
    mnem      = mnemonic(opcode_q);
    dest_tens = (dest_q >= 4'd10);
    dest_ones = dest_tens ? (dest_q - 4'd10) : dest_q;
    l1_pos    = 4'(nxt_idx - 6'd1);
    l2_pos    = 4'(nxt_idx - L2_IDX - 6'd1);
    nxt_byte  = PAD_CHAR;
    nxt_cmd   = 1'b0;
    if (nxt_idx == L2_IDX) begin
      nxt_byte = LINE2_ADDR;
      nxt_cmd  = 1'b1;
    end else if (nxt_idx < L2_IDX) begin
      case (l1_pos)
        4'd0:    nxt_byte = mnem[31:24];
        4'd1:    nxt_byte = mnem[23:16];
        4'd2:    nxt_byte = mnem[15:8];
        4'd3:    nxt_byte = mnem[7:0];
        4'd4:    nxt_byte = ASCII_SPACE;
        4'd5:    nxt_byte = ASCII_R;
        4'd6:    nxt_byte = dest_tens ? (ASCII_0 + 8'd1) : ASCII_0;
        4'd7:    nxt_byte = ASCII_0 + {4'd0, dest_ones};
        default: nxt_byte = PAD_CHAR;
      endcase
    end else begin
      case (l2_pos)
        4'd0:    nxt_byte = ASCII_EQ;
        4'd1:    nxt_byte = sign_q ? ASCII_MINUS : ASCII_PLUS;
        4'd2:    nxt_byte = ASCII_0 + {4'd0, bcd_digits[19:16]};
        4'd3:    nxt_byte = ASCII_0 + {4'd0, bcd_digits[15:12]};
        4'd4:    nxt_byte = ASCII_0 + {4'd0, bcd_digits[11:8]};
        4'd5:    nxt_byte = ASCII_0 + {4'd0, bcd_digits[7:4]};
        4'd6:    nxt_byte = ASCII_0 + {4'd0, bcd_digits[3:0]};
        default: nxt_byte = PAD_CHAR;
      endcase
    end
  end

  // Sequencer: capture, convert, then stream one byte per accepted transfer
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    dest_d   = dest_q;
    res_d    = res_q;
    sign_d   = sign_q;
    idx_d    = idx_q;
    data_d   = data_q;
    cmd_d    = cmd_q;
    bcd_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opcode_d = opcode;
          dest_d   = dest_reg_addr;
          res_d    = alu_result;
          state_d  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        sign_d   = res_q[15];
        bcd_load = 1'b1;
        state_d  = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (bcd_ready) begin
          idx_d   = 6'd0;
          data_d  = LINE1_ADDR;
          cmd_d   = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (char_ready) begin
          if (idx_q == LAST_IDX) begin
            data_d  = 8'h00;
            cmd_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            idx_d  = nxt_idx;
            data_d = nxt_byte;
            cmd_d  = nxt_cmd;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; async reset abandons any message in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      dest_q   <= '0;
      res_q    <= '0;
      sign_q   <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      cmd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      dest_q   <= dest_d;
      res_q    <= res_d;
      sign_q   <= sign_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      cmd_q    <= cmd_d;
    end
  end

  assign char_valid  = (state_q == ST_SEND);
  assign char_data   = data_q;
  assign char_is_cmd = cmd_q;
  assign busy        = (state_q == ST_CAPTURE) || (state_q == ST_CONVERT) || (state_q == ST_SEND);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_lcd_msg_formatter.sv
// tb/tb_lcd_msg_formatter.sv - scoreboard bench for the LCD message formatter
module tb_lcd_msg_formatter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [3:0]  dest_reg_addr = '0;
  logic [15:0] alu_result = '0;
  logic        char_ready = 1'b1;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_is_cmd;
  logic        busy;
  logic        done;

  always #10 clk = ~clk;

  lcd_msg_formatter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .opcode        (opcode),
    .dest_reg_addr (dest_reg_addr),
    .alu_result    (alu_result),
    .char_ready    (char_ready),
    .char_valid    (char_valid),
    .char_data     (char_data),
    .char_is_cmd   (char_is_cmd),
    .busy          (busy),
    .done          (done)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_start = 0;
  int first_valid_cyc = 0;
  int done_cyc = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  bit seen_valid = 1'b0;
  bit bp_mode = 1'b0;
  bit prev_stall = 1'b0;
  logic [8:0] prev_byte = '0;
  logic [8:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    char_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic string mnem_of(input int op);
    case (op)
      0: return "LOAD";
      1: return "ADD ";
      2: return "ADDI";
      3: return "SUB ";
      4: return "SUBI";
      5: return "MUL ";
      6: return "CLR ";
      7: return "DPL ";
      default: return "????";
    endcase
  endfunction

  // Reference model: build the whole 34-entry message as {is_cmd, byte}
  task automatic push_expected(input logic [3:0] op, input logic [3:0] d, input logic [15:0] r);
    string m;
    int mag, dv, p;
    bit neg;
    logic [7:0] l1[16];
    logic [7:0] l2[16];
    m  = mnem_of(int'(op));
    dv = int'(d);
    mag = int'(r);
    neg = r[15];
    if (neg) mag = 65536 - mag;
    for (int i = 0; i < 16; i++) begin
      l1[i] = 8'h20;
      l2[i] = 8'h20;
    end
    for (int i = 0; i < 4; i++) l1[i] = m.getc(i);
    l1[4] = " ";
    l1[5] = "R";
    l1[6] = 8'(48 + dv / 10);
    l1[7] = 8'(48 + dv % 10);
    l2[0] = "=";
    l2[1] = neg ? "-" : "+";
    p = 10000;
    for (int k = 0; k < 5; k++) begin
      l2[2 + k] = 8'(48 + (mag / p) % 10);
      p = p / 10;
    end
    exp_q.push_back({1'b1, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, l1[i]});
    exp_q.push_back({1'b1, 8'hC0});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, l2[i]});
  endtask

  // Monitor: pop and compare on every accepted transfer, check hold-while-stalled
  always @(negedge clk) begin
    logic [8:0] e;
    logic [8:0] a;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      a = {char_is_cmd, char_data};
      if (char_valid && !seen_valid) begin
        seen_valid = 1'b1;
        first_valid_cyc = cyc - t_start + 1;
      end
      if (prev_stall && char_valid)
        check("hold_while_stalled", int'(a), int'(prev_byte));
      if (char_valid && char_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("byte%0d", xfer_cnt), int'(a), int'(e));
        end
        xfer_cnt++;
      end
      prev_stall = char_valid && !char_ready;
      prev_byte  = a;
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t_start + 1;
        check("busy_low_at_done", int'(busy), 0);
      end
    end
  end

  task automatic issue_start(input logic [3:0] op, input logic [3:0] d, input logic [15:0] r);
    xfer_cnt   = 0;
    done_cnt   = 0;
    seen_valid = 1'b0;
    @(posedge clk); #1;
    opcode = op; dest_reg_addr = d; alu_result = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t_start = cyc;
    opcode = 4'($urandom); dest_reg_addr = 4'($urandom); alu_result = 16'($urandom);
  endtask

  task automatic run_msg(input logic [3:0] op, input logic [3:0] d, input logic [15:0] r, input bit guard);
    int n;
    push_expected(op, d, r);
    issue_start(op, d, r);
    @(negedge clk);
    check("busy_in_capture", int'(busy), 1);
    if (guard) begin
      repeat (4) @(posedge clk);
      #1;
      opcode = ~op; dest_reg_addr = ~d; alu_result = ~r; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_seen", int'(done_cnt != 0), 1);
    repeat (3) @(negedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("transfer_count", xfer_cnt, 34);
    check("queue_drained", exp_q.size(), 0);
    if (!bp_mode) begin
      check("first_valid_cycle", first_valid_cyc, 18);
      check("done_cycle", done_cyc, 52);
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_char_valid"}, int'(char_valid), 0);
    check({tag, "_char_data"}, int'(char_data), 0);
    check({tag, "_char_is_cmd"}, int'(char_is_cmd), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal and numeric extremes
    run_msg(4'd1, 4'd3, 16'd123, 1'b0);
    run_msg(4'd2, 4'd7, 16'h8000, 1'b0);
    run_msg(4'd3, 4'd9, 16'hFFFF, 1'b0);
    run_msg(4'd5, 4'd0, 16'h0000, 1'b0);
    run_msg(4'd7, 4'd12, 16'h7FFF, 1'b0);

    // Opcode table corners
    run_msg(4'hA, 4'd15, 16'd42, 1'b0);
    run_msg(4'h0, 4'd15, 16'hFF85, 1'b0);

    // Second start while converting must be ignored
    run_msg(4'd4, 4'd10, 16'd31000, 1'b1);

    // Backpressure
    bp_mode = 1'b1;
    run_msg(4'd1, 4'd3, 16'd123, 1'b0);
    for (int i = 0; i < 4; i++)
      run_msg(4'($urandom), 4'($urandom), 16'($urandom), 1'b0);
    bp_mode = 1'b0;

    // Reset in the middle of the stream
    push_expected(4'd6, 4'd2, 16'd555);
    issue_start(4'd6, 4'd2, 16'd555);
    n = 0;
    while (xfer_cnt < 10 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    check("reached_index10", int'(xfer_cnt >= 10), 1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk); #2;
    reset_n = 1'b1;
    run_msg(4'd6, 4'd2, 16'd555, 1'b0);

    // Random messages with full-rate ready
    for (int i = 0; i < 4; i++)
      run_msg(4'($urandom), 4'($urandom), 16'($urandom), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
